// File: rtl/sys_io_regs_pkg.sv
// sys_io_regs_pkg: shared constants for the system I/O register block.
package sys_io_regs_pkg;
  localparam logic [4:0] MISC_INVERT = 5'h03;
  localparam logic [4:0] MISC_COIN0 = 5'h08;
  localparam logic [4:0] MISC_COIN1 = 5'h09;
  localparam logic [4:0] MISC_FLIP = 5'h10;
  localparam logic [7:0] LATCH_RST_DEF = 8'h00;
  localparam logic [15:0] SCROLL_RST_DEF = 16'h0000;
  typedef enum logic [2:0] {SRC_FGX, SRC_FGY, SRC_BGX, SRC_BGY, SRC_LATCH, SRC_MISC} src_e;
  localparam int NSRC = 6;
endpackage

// File: rtl/sys_io_regs_edge_strobe.sv
// edge_strobe: registered rising-edge detector that only arms after the input has been seen low.
module edge_strobe (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic low_seen;
  always_ff @(posedge clk or posedge reset)
    if (reset) low_seen <= 1'b0;
    else low_seen <= !in;
  // A level still high out of reset never fires until it drops and returns.
  assign pulse = in & low_seen;
endmodule

// File: rtl/sys_io_regs.sv
// sys_io_regs: M68K-written scroll/misc registers and the 68K-to-Z80 sound command latch.
module sys_io_regs
  import sys_io_regs_pkg::*;
#(
  parameter logic [7:0] LATCH_RST = LATCH_RST_DEF,
  parameter logic [15:0] SCROLL_RST = SCROLL_RST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] m68k_din,
  input  logic        m68k_rw,
  input  logic        m68k_uds_n,
  input  logic        m68k_lds_n,
  input  logic        fg_scroll_x_cs,
  input  logic        fg_scroll_y_cs,
  input  logic        bg_scroll_x_cs,
  input  logic        bg_scroll_y_cs,
  input  logic        sound_latch_cs,
  input  logic        misc_cs,
  input  logic [4:0]  m68k_a5_1,
  input  logic        z80_latch_cs,
  input  logic        z80_rd_n,
  output logic [15:0] fg_scroll_x,
  output logic [15:0] fg_scroll_y,
  output logic [15:0] bg_scroll_x,
  output logic [15:0] bg_scroll_y,
  output logic        flip,
  output logic        invert_ctrl,
  output logic        coin_ctr0,
  output logic        coin_ctr1,
  output logic [7:0]  sound_latch,
  output logic        z80_nmi_n,
  output logic        sound_overrun
);
  logic strobe, rd_rise, rd_end, lat_wr, pending, pending_d;
  logic [NSRC-1:0] sel, commit;
  logic [3:0][15:0] scroll;
  assign strobe = !m68k_rw & (!m68k_uds_n | !m68k_lds_n);
  assign sel = {misc_cs, sound_latch_cs, bg_scroll_y_cs, bg_scroll_x_cs, fg_scroll_y_cs, fg_scroll_x_cs};
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    edge_strobe u_es (.clk(clk), .reset(reset), .in(sel[g] & strobe), .pulse(commit[g]));
  end
  edge_strobe u_rd (.clk(clk), .reset(reset), .in(z80_rd_n), .pulse(rd_rise));
  assign rd_end = rd_rise & z80_latch_cs;
  assign lat_wr = commit[SRC_LATCH] & !m68k_lds_n;
  // A new command beats a concurrent read-end so it is never silently dropped.
  assign pending_d = lat_wr | (pending & !rd_end);
  assign {bg_scroll_y, bg_scroll_x, fg_scroll_y, fg_scroll_x} = scroll;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scroll <= {4{SCROLL_RST}};
      sound_latch <= LATCH_RST;
      pending <= 1'b0;
      z80_nmi_n <= 1'b1;
      sound_overrun <= 1'b0;
      flip <= 1'b0;
      invert_ctrl <= 1'b0;
      coin_ctr0 <= 1'b0;
      coin_ctr1 <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (commit[i] && !m68k_uds_n) scroll[i][15:8] <= m68k_din[15:8];
        if (commit[i] && !m68k_lds_n) scroll[i][7:0] <= m68k_din[7:0];
      end
      invert_ctrl <= (commit[SRC_MISC] && m68k_a5_1 == MISC_INVERT) ? |m68k_din : invert_ctrl;
      coin_ctr0 <= (commit[SRC_MISC] && m68k_a5_1 == MISC_COIN0) ? m68k_din[0] : coin_ctr0;
      coin_ctr1 <= (commit[SRC_MISC] && m68k_a5_1 == MISC_COIN1) ? m68k_din[0] : coin_ctr1;
      flip <= (commit[SRC_MISC] && m68k_a5_1 == MISC_FLIP) ? m68k_din[0] : flip;
      sound_latch <= lat_wr ? m68k_din[7:0] : sound_latch;
      sound_overrun <= sound_overrun | (lat_wr & pending);
      pending <= pending_d;
      z80_nmi_n <= !pending_d;
    end
endmodule

// File: tb/tb_sys_io_regs.sv
// tb_sys_io_regs: directed stimulus against a cycle-level behavioural model plus literal spot checks.
module tb_sys_io_regs;
  logic clk = 0, reset = 1;
  logic [15:0] m68k_din = 0;
  logic m68k_rw = 1, m68k_uds_n = 1, m68k_lds_n = 1;
  logic [5:0] cs = 0;
  logic [4:0] m68k_a5_1 = 0;
  logic z80_latch_cs = 0, z80_rd_n = 1;
  logic [15:0] fg_scroll_x, fg_scroll_y, bg_scroll_x, bg_scroll_y;
  logic flip, invert_ctrl, coin_ctr0, coin_ctr1, z80_nmi_n, sound_overrun;
  logic [7:0] sound_latch;
  int checks = 0, errors = 0;

  sys_io_regs dut (
    .clk(clk), .reset(reset), .m68k_din(m68k_din), .m68k_rw(m68k_rw),
    .m68k_uds_n(m68k_uds_n), .m68k_lds_n(m68k_lds_n),
    .fg_scroll_x_cs(cs[0]), .fg_scroll_y_cs(cs[1]), .bg_scroll_x_cs(cs[2]),
    .bg_scroll_y_cs(cs[3]), .sound_latch_cs(cs[4]), .misc_cs(cs[5]),
    .m68k_a5_1(m68k_a5_1), .z80_latch_cs(z80_latch_cs), .z80_rd_n(z80_rd_n),
    .fg_scroll_x(fg_scroll_x), .fg_scroll_y(fg_scroll_y), .bg_scroll_x(bg_scroll_x),
    .bg_scroll_y(bg_scroll_y), .flip(flip), .invert_ctrl(invert_ctrl),
    .coin_ctr0(coin_ctr0), .coin_ctr1(coin_ctr1), .sound_latch(sound_latch),
    .z80_nmi_n(z80_nmi_n), .sound_overrun(sound_overrun)
  );

  always #5 clk = ~clk;

  // Model: a bus cycle is "the select level while a write strobe is active";
  // it acts once, when the cycle starts after a period of inactivity.
  logic [15:0] m_scroll [4];
  logic [7:0] m_latch;
  logic m_pend, m_ovr, m_flip, m_inv, m_c0, m_c1, m_rd_idle;
  logic m_idle [6];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_scroll[i] = 16'h0000;
      for (int i = 0; i < 6; i++) m_idle[i] = 0;
      m_latch = 8'h00; m_pend = 0; m_ovr = 0; m_flip = 0; m_inv = 0; m_c0 = 0; m_c1 = 0;
      m_rd_idle = 0;
    end else begin
      bit active, starts, rd_done, new_cmd;
      new_cmd = 0;
      for (int i = 0; i < 6; i++) begin
        active = cs[i] && !m68k_rw && (!m68k_uds_n || !m68k_lds_n);
        starts = active && m_idle[i];
        m_idle[i] = !active;
        if (starts && i < 4) begin
          if (!m68k_uds_n) m_scroll[i][15:8] = m68k_din[15:8];
          if (!m68k_lds_n) m_scroll[i][7:0] = m68k_din[7:0];
        end
        if (starts && i == 4 && !m68k_lds_n) new_cmd = 1;
        if (starts && i == 5) begin
          if (m68k_a5_1 == 5'd3) m_inv = (m68k_din != 0);
          if (m68k_a5_1 == 5'd8) m_c0 = m68k_din[0];
          if (m68k_a5_1 == 5'd9) m_c1 = m68k_din[0];
          if (m68k_a5_1 == 5'd16) m_flip = m68k_din[0];
        end
      end
      rd_done = z80_rd_n && m_rd_idle && z80_latch_cs;
      m_rd_idle = !z80_rd_n;
      if (new_cmd) begin
        if (m_pend) m_ovr = 1;
        m_latch = m68k_din[7:0];
        m_pend = 1;
      end else if (rd_done) m_pend = 0;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("fg_scroll_x", fg_scroll_x, m_scroll[0]);
    check("fg_scroll_y", fg_scroll_y, m_scroll[1]);
    check("bg_scroll_x", bg_scroll_x, m_scroll[2]);
    check("bg_scroll_y", bg_scroll_y, m_scroll[3]);
    check("sound_latch", {8'h00, sound_latch}, {8'h00, m_latch});
    check("z80_nmi_n", {15'd0, z80_nmi_n}, {15'd0, !m_pend});
    check("sound_overrun", {15'd0, sound_overrun}, {15'd0, m_ovr});
    check("flip", {15'd0, flip}, {15'd0, m_flip});
    check("invert_ctrl", {15'd0, invert_ctrl}, {15'd0, m_inv});
    check("coin_ctr0", {15'd0, coin_ctr0}, {15'd0, m_c0});
    check("coin_ctr1", {15'd0, coin_ctr1}, {15'd0, m_c1});
  end

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] mdl, input logic [15:0] exp);
    check({name, "_dut"}, act, exp);
    check({name, "_model"}, mdl, exp);
  endtask

  task automatic bus_wr(input int s, input logic [4:0] a, input logic [15:0] d, input logic u, input logic l, input int hold);
    @(posedge clk); #1;
    cs = 0; cs[s] = 1; m68k_a5_1 = a; m68k_din = d; m68k_rw = 0; m68k_uds_n = u; m68k_lds_n = l;
    repeat (hold) @(posedge clk);
    #1;
    cs = 0; m68k_rw = 1; m68k_uds_n = 1; m68k_lds_n = 1;
  endtask

  task automatic z80_read();
    @(posedge clk); #1;
    z80_latch_cs = 1; z80_rd_n = 0;
    repeat (3) @(posedge clk);
    #1 z80_rd_n = 1;
    @(negedge clk);
    lit("nmi_during_read", {15'd0, z80_nmi_n}, {15'd0, !m_pend}, 16'h0000);
    @(posedge clk); #1;
    z80_latch_cs = 0;
    @(negedge clk);
    lit("nmi_after_read", {15'd0, z80_nmi_n}, {15'd0, !m_pend}, 16'h0001);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    lit("rst_fgx", fg_scroll_x, m_scroll[0], 16'h0000);
    lit("rst_nmi", {15'd0, z80_nmi_n}, {15'd0, !m_pend}, 16'h0001);
    bus_wr(0, 0, 16'h1234, 0, 0, 6);
    @(negedge clk);
    lit("fgx_word", fg_scroll_x, m_scroll[0], 16'h1234);
    bus_wr(4, 0, 16'h005A, 1, 0, 6);
    @(negedge clk);
    lit("latch_5a", {8'h00, sound_latch}, {8'h00, m_latch}, 16'h005A);
    lit("nmi_set", {15'd0, z80_nmi_n}, {15'd0, !m_pend}, 16'h0000);
    lit("one_commit", {15'd0, sound_overrun}, {15'd0, m_ovr}, 16'h0000);
    z80_read();
    bus_wr(3, 0, 16'hABCD, 1, 0, 2);
    @(negedge clk);
    lit("bgy_low", bg_scroll_y, m_scroll[3], 16'h00CD);
    bus_wr(1, 0, 16'hBEEF, 0, 1, 3);
    @(negedge clk);
    lit("fgy_high", fg_scroll_y, m_scroll[1], 16'hBE00);
    bus_wr(2, 0, 16'h55AA, 0, 0, 1);
    bus_wr(5, 5'h03, 16'h0100, 0, 0, 2);
    bus_wr(5, 5'h08, 16'h0001, 0, 0, 2);
    bus_wr(5, 5'h09, 16'h0003, 0, 0, 2);
    bus_wr(5, 5'h10, 16'h0001, 0, 0, 2);
    bus_wr(5, 5'h04, 16'hFFFF, 0, 0, 2);
    @(negedge clk);
    lit("misc_inv", {15'd0, invert_ctrl}, {15'd0, m_inv}, 16'h0001);
    lit("misc_flip", {15'd0, flip}, {15'd0, m_flip}, 16'h0001);
    bus_wr(5, 5'h03, 16'h0000, 0, 0, 2);
    bus_wr(5, 5'h08, 16'h0002, 0, 0, 2);
    bus_wr(4, 0, 16'h0011, 1, 0, 2);
    bus_wr(4, 0, 16'h0022, 1, 0, 2);
    @(negedge clk);
    lit("latch_22", {8'h00, sound_latch}, {8'h00, m_latch}, 16'h0022);
    lit("overrun", {15'd0, sound_overrun}, {15'd0, m_ovr}, 16'h0001);
    bus_wr(4, 0, 16'h0099, 0, 1, 2);
    @(negedge clk);
    lit("latch_uds_ign", {8'h00, sound_latch}, {8'h00, m_latch}, 16'h0022);
    z80_read();
    bus_wr(4, 0, 16'h0033, 1, 0, 2);
    @(posedge clk); #1;
    z80_latch_cs = 1; z80_rd_n = 0;
    repeat (2) @(posedge clk);
    #1;
    z80_rd_n = 1; cs[4] = 1; m68k_rw = 0; m68k_lds_n = 0; m68k_din = 16'h0044;
    @(posedge clk); #1;
    cs = 0; m68k_rw = 1; m68k_lds_n = 1; z80_latch_cs = 0;
    @(negedge clk);
    lit("align_nmi", {15'd0, z80_nmi_n}, {15'd0, !m_pend}, 16'h0000);
    lit("align_latch", {8'h00, sound_latch}, {8'h00, m_latch}, 16'h0044);
    @(posedge clk); #1;
    cs[4] = 1; m68k_rw = 0; m68k_lds_n = 0; m68k_din = 16'h0077;
    @(posedge clk);
    #3 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit("rst_held_latch", {8'h00, sound_latch}, {8'h00, m_latch}, 16'h0000);
    lit("rst_held_nmi", {15'd0, z80_nmi_n}, {15'd0, !m_pend}, 16'h0001);
    lit("rst_held_fgx", fg_scroll_x, m_scroll[0], 16'h0000);
    @(posedge clk); #1;
    cs[4] = 0;
    @(posedge clk); #1;
    cs[4] = 1;
    @(posedge clk); #1;
    cs = 0; m68k_rw = 1; m68k_lds_n = 1;
    @(negedge clk);
    lit("retoggle_latch", {8'h00, sound_latch}, {8'h00, m_latch}, 16'h0077);
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sys_io_regs.md
SYS_IO_REGS -- requirements
Module: sys_io_regs

Interface
REQ-001 SHALL have parameter LATCH_RST, default 8'h00: reset value of the sound command latch.
REQ-002 SHALL have parameter SCROLL_RST, default 16'h0000: reset value of all four scroll registers.
REQ-003 SHALL have port clk, input, 1: single system clock for all state.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port m68k_din, input, 16: M68K write data bus.
REQ-006 SHALL have port m68k_rw, input, 1: 1 = read, 0 = write.
REQ-007 SHALL have ports m68k_uds_n and m68k_lds_n, input, 1 each: byte strobes, active low.
REQ-008 SHALL have ports fg_scroll_x_cs, fg_scroll_y_cs, bg_scroll_x_cs, bg_scroll_y_cs, sound_latch_cs, input, 1 each: decoded selects from the address decoder.
REQ-009 SHALL have port misc_cs, input, 1: select for 0x0f0040-0x0f006f; m68k_a5_1, input, 5 (address bits 5:1), picks the register inside it.
REQ-010 SHALL have ports z80_latch_cs and z80_rd_n, input, 1 each: Z80 latch read select and read strobe.
REQ-011 SHALL have outputs fg_scroll_x, fg_scroll_y, bg_scroll_x, bg_scroll_y, 16 each: scroll values.
REQ-012 SHALL have outputs flip, invert_ctrl, coin_ctr0, coin_ctr1, 1 each.
REQ-013 SHALL have outputs sound_latch (8: command byte), z80_nmi_n (1: active-low NMI request), sound_overrun (1: sticky flag).

Function
REQ-014 SHALL derive wr = any select & !m68k_rw & (!uds_n | !lds_n), and commit exactly once per bus cycle, on the first clk where wr is high after being low (registered edge detect).
REQ-015 SHALL update each scroll register byte-lane-wise: [15:8] only when uds_n = 0, [7:0] only when lds_n = 0, with a one-clk latency from the commit edge.
REQ-016 SHALL decode misc writes on a5_1 as follows: 5'h03 sets invert_ctrl = |din; 5'h08 sets coin_ctr0 = din[0]; 5'h09 sets coin_ctr1 = din[0]; 5'h10 sets flip = din[0]; all other codes are ignored.
REQ-017 SHALL, on a sound_latch_cs commit with lds_n = 0, load sound_latch = din[7:0] and set pending = 1; a commit with only uds_n low SHALL be ignored.
REQ-018 SHALL drive z80_nmi_n = !pending, registered.
REQ-019 SHALL clear pending on the rising edge of z80_rd_n while z80_latch_cs is high, i.e. at the end of the Z80 read cycle, so the byte stays stable throughout the read.
REQ-020 SHALL, when a 68K latch commit and a Z80 read-end occur in the same clk, let the write win: pending stays 1 and the latch takes the new byte.
REQ-021 SHALL set sound_overrun when a latch commit arrives while pending = 1; it SHALL clear only on reset.
REQ-022 SHALL keep every select held for many clks (wait-stated cycles) to one commit only; a new commit requires the select to deassert first.

Reset
REQ-023 SHALL reset as follows: scroll registers to SCROLL_RST; sound_latch to LATCH_RST; pending, overrun, flip, invert_ctrl, coin counters and edge-detect state to 0; z80_nmi_n to 1.
REQ-024 SHALL, when reset asserts mid bus cycle, lose the cycle; a select still held after reset releases SHALL not commit until it deasserts and re-asserts.

Structure
REQ-025 SHALL place the misc register codes (03, 08, 09, 10) and the reset parameters as constants in the shared core package.
REQ-026 SHALL use one sub-module, edge_strobe (registered rising-edge detector), instantiated per write source and for the Z80 read-end detect.

Verification
REQ-027 Word write 16'h1234 to fg_scroll_x with both strobes low, select held for 6 clks -> fg_scroll_x = 16'h1234 after 1 clk, with exactly one commit.
REQ-028 Write 16'hABCD to bg_scroll_y with only lds_n low, starting from 16'h0000 -> bg_scroll_y = 16'h00CD.
REQ-029 Latch write 8'h5A -> sound_latch = 8'h5A and z80_nmi_n = 0; Z80 read with rd_n low then high -> z80_nmi_n = 1 one clk after the rd_n rise.
REQ-030 Latch write 8'h11, then 8'h22 before the Z80 reads -> sound_latch = 8'h22 and sound_overrun = 1.
REQ-031 Latch write aligned with a Z80 read-end in the same clk -> z80_nmi_n stays 0 and sound_latch holds the new byte.
REQ-032 Reset pulsed while sound_latch_cs is held -> all outputs at reset values, and no commit until the select toggles.
